// File: rtl/cyc_unshift_pkg.sv
// Shared circulant-shift helpers used by both the forward and inverse shifters.
// Provides the null-shift code and the lane destination index for a rotation.
package cyc_unshift_pkg;

    // The null-edge shift code is all ones at whatever lane width is in use.
    function automatic logic [31:0] null_shift(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Destination lane of source lane 'lane' after rotating left by 'step' lanes.
    function automatic int unsigned rot_lane(input int unsigned lane,
                                             input int unsigned step,
                                             input int unsigned d);
        return (lane + step) % d;
    endfunction

endpackage

// File: rtl/cyc_rot_stage.sv
// One registered rotate stage: conditionally rotates the block left by 'step' lanes.
// Latency 1 cycle; loads only when en is high, otherwise holds (backpressure stall).
module cyc_rot_stage
    import cyc_unshift_pkg::*;
#(
    parameter int unsigned data_w = 8,
    parameter int unsigned D      = 5,
    parameter int unsigned step   = 1,
    parameter int unsigned sw     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                in_valid,
    input  logic                in_null,
    input  logic [sw-1:0]       in_shift,
    input  logic [data_w*D-1:0] in_data,
    output logic                out_valid,
    output logic                out_null,
    output logic [sw-1:0]       out_shift,
    output logic [data_w*D-1:0] out_data
);

    logic [data_w*D-1:0] rot;

    for (genvar k = 0; k < D; k++) begin : g_lane
        localparam int unsigned dst = rot_lane(int'(k), step, D);
        assign rot[dst*data_w +: data_w] = in_data[k*data_w +: data_w];
    end

    // Bit 0 of the remaining shift belongs to this stage; the rest moves down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_null  <= 1'b0;
            out_shift <= '0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_null  <= in_null;
            out_shift <= in_shift >> 1;
            out_data  <= in_shift[0] ? rot : in_data;
        end
    end

endmodule

// File: rtl/cyc_unshift.sv
// Inverse circulant shifter: rotates a check-order block back to variable order.
// Latency ceil(log2(D)) cycles; whole pipeline stalls when out_valid && !out_ready.
module cyc_unshift
    import cyc_unshift_pkg::*;
#(
    parameter int unsigned data_w = 8,
    parameter int unsigned D      = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [data_w-1:0]   in_shift,
    input  logic [data_w*D-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [data_w*D-1:0] out_data,
    output logic                out_null,
    output logic                err_range
);

    localparam int unsigned         P       = $clog2(D);
    localparam logic [data_w-1:0]   null_sh = data_w'(null_shift(data_w));
    localparam logic [data_w-1:0]   d_lim   = data_w'(D);

    logic                en;
    logic                is_null;
    logic                is_bad;
    logic                vld_s [P+1];
    logic                nul_s [P+1];
    logic [P-1:0]        sh_s  [P+1];
    logic [data_w*D-1:0] dat_s [P+1];
    logic                unused_sh;

    assign en       = out_ready || !out_valid;
    assign in_ready = en;
    assign is_null  = (in_shift == null_sh);
    assign is_bad   = !is_null && (in_shift >= d_lim);

    // Null and out-of-range blocks enter as zeros with no rotation.
    always_comb begin
        vld_s[0] = in_valid;
        nul_s[0] = is_null;
        sh_s[0]  = '0;
        dat_s[0] = '0;
        if (!is_null && !is_bad) begin
            sh_s[0]  = in_shift[P-1:0];
            dat_s[0] = in_data;
        end
    end

    for (genvar i = 0; i < P; i++) begin : g_stage
        cyc_rot_stage #(
            .data_w (data_w),
            .D      (D),
            .step   (32'd1 << i),
            .sw     (P)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (vld_s[i]),
            .in_null   (nul_s[i]),
            .in_shift  (sh_s[i]),
            .in_data   (dat_s[i]),
            .out_valid (vld_s[i+1]),
            .out_null  (nul_s[i+1]),
            .out_shift (sh_s[i+1]),
            .out_data  (dat_s[i+1])
        );
    end

    assign out_valid = vld_s[P];
    assign out_null  = nul_s[P];
    assign out_data  = dat_s[P];
    assign unused_sh = ^sh_s[P];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_range <= 1'b0;
        end else if (in_valid && en && is_bad) begin
            err_range <= 1'b1;
        end
    end

endmodule
